// File: rtl/bus_defs.sv
// Shared types and constants for the CPU-bus to SRAM bridge.
package bus_defs;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    ACCESS,
    DONE,
    HOLD
  } bridge_state_t;

  localparam logic [15:0] FAULT_DATA = 16'hDEAD;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  // True when any bus address bit above the SRAM word-address range is set.
  function automatic logic upperBitsSet(input logic [15:0] busAddr, input int addrW);
    return (busAddr >> addrW) != 16'd0;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable saturating down-counter used to time the bridge wait states.
module wait_counter
  import bus_defs::*;
(
  input  logic             Clock,
  input  logic             nReset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             enable,
  output logic             zero,
  output logic             one
);

  logic [CNT_W-1:0] countReg;

  // Stops at zero instead of wrapping.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= loadValue;
    end else if (enable && (countReg != '0)) begin
      countReg <= countReg - 1'b1;
    end
  end

  assign zero = (countReg == '0);
  assign one  = (countReg == CNT_W'(1));

endmodule

// File: rtl/mem_bridge.sv
// Multiplexed CPU bus to single-port synchronous SRAM bridge with fixed wait states.
// Define MEM_BRIDGE_FAULT_EN to trap bus addresses above the SRAM range.
module mem_bridge
  import bus_defs::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [15:0]       CpuDataOut,
  output logic [15:0]       CpuDataIn,
  input  logic              ALE,
  input  logic              nME,
  input  logic              nOE,
  input  logic              ENB,
  output logic              nWait,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       MemWData,
  input  logic [15:0]       MemRData,
  output logic              MemCe,
  output logic              MemWe,
  output logic              Fault
);

`ifdef MEM_BRIDGE_FAULT_EN
  localparam int AREG_W = 16;
`else
  localparam int AREG_W = ADDR_W;
`endif

  bridge_state_t stateReg, stateNext;

  logic [AREG_W-1:0] addrReg;
  logic [15:0]       wrReg;
  logic [15:0]       rdReg;
  logic              isWriteReg;
  logic              addrLoad;
  logic              cmdCapture;
  logic              cntLoad;
  logic              cntEnable;
  logic              cntZero;
  logic              cntOne;
  logic              addrFault;
  logic [15:0]       doneData;

`ifdef MEM_BRIDGE_FAULT_EN
  logic faultReg;

  assign addrFault = upperBitsSet(addrReg, ADDR_W);
  assign doneData  = faultReg ? FAULT_DATA : MemRData;
  assign Fault     = (stateReg == DONE) && faultReg;
`else
  assign addrFault = 1'b0;
  assign doneData  = MemRData;
  assign Fault     = 1'b0;
`endif

  wait_counter uWaitCounter (
    .Clock     (Clock),
    .nReset    (nReset),
    .load      (cntLoad),
    .loadValue (CNT_W'(WAIT_STATES)),
    .enable    (cntEnable),
    .zero      (cntZero),
    .one       (cntOne)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      stateReg   <= IDLE;
      addrReg    <= '0;
      wrReg      <= '0;
      rdReg      <= '0;
      isWriteReg <= 1'b0;
`ifdef MEM_BRIDGE_FAULT_EN
      faultReg   <= 1'b0;
`endif
    end else begin
      stateReg <= stateNext;
      if (addrLoad) begin
        addrReg <= CpuDataOut[AREG_W-1:0];
      end
      if (cmdCapture) begin
        isWriteReg <= nOE;
        wrReg      <= CpuDataOut;
`ifdef MEM_BRIDGE_FAULT_EN
        faultReg   <= addrFault;
`endif
      end
      if (stateReg == DONE) begin
        rdReg <= doneData;
      end
    end
  end

  always_comb begin
    stateNext  = stateReg;
    addrLoad   = 1'b0;
    cmdCapture = 1'b0;
    cntLoad    = 1'b0;
    cntEnable  = 1'b0;
    nWait      = 1'b1;
    MemCe      = 1'b0;
    MemWe      = 1'b0;
    CpuDataIn  = rdReg;
    unique case (stateReg)
      IDLE: begin
        if (ALE) begin
          addrLoad  = 1'b1;
          stateNext = ADDR;
        end
      end
      ADDR: begin
        if (ALE) begin
          addrLoad = 1'b1;
        end else if (!nME) begin
          cmdCapture = 1'b1;
          cntLoad    = 1'b1;
          // A write without the bus driver enabled is silently discarded.
          if (nOE && !ENB) begin
            stateNext = IDLE;
          end else if (addrFault) begin
            stateNext = DONE;
          end else if (WAIT_STATES == 0) begin
            stateNext = ACCESS;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        nWait = 1'b0;
        if (nME) begin
          stateNext = IDLE;
        end else begin
          cntEnable = 1'b1;
          if (cntOne || cntZero) begin
            stateNext = ACCESS;
          end
        end
      end
      ACCESS: begin
        nWait     = 1'b0;
        MemCe     = 1'b1;
        MemWe     = isWriteReg;
        stateNext = DONE;
      end
      DONE: begin
        CpuDataIn = doneData;
        stateNext = nME ? IDLE : HOLD;
      end
      HOLD: begin
        if (nME) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign MemAddr  = addrReg[ADDR_W-1:0];
  assign MemWData = wrReg;

endmodule
